// File: rtl/ps2_pkg.sv
// PS/2 set-2 decoder shared definitions.
// Prefix bytes, modifier codes, FSM states, event struct, ASCII table.
package ps2_pkg;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Bytes still to swallow after the E1 of a Pause sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    typedef struct packed {
        logic [7:0] ascii;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_evt_t;

    // Lower-case letter for a letter key, 0 otherwise
    function automatic logic [7:0] letter_of(input logic [7:0] code);
        case (code)
            8'h1C: return 8'h61;  8'h32: return 8'h62;
            8'h21: return 8'h63;  8'h23: return 8'h64;
            8'h24: return 8'h65;  8'h2B: return 8'h66;
            8'h34: return 8'h67;  8'h33: return 8'h68;
            8'h43: return 8'h69;  8'h3B: return 8'h6A;
            8'h42: return 8'h6B;  8'h4B: return 8'h6C;
            8'h3A: return 8'h6D;  8'h31: return 8'h6E;
            8'h44: return 8'h6F;  8'h4D: return 8'h70;
            8'h15: return 8'h71;  8'h2D: return 8'h72;
            8'h1B: return 8'h73;  8'h2C: return 8'h74;
            8'h3C: return 8'h75;  8'h2A: return 8'h76;
            8'h1D: return 8'h77;  8'h22: return 8'h78;
            8'h35: return 8'h79;  8'h1A: return 8'h7A;
            default: return 8'h00;
        endcase
    endfunction

    // {unshifted, shifted} pair for digit/symbol keys, 0 otherwise
    function automatic logic [15:0] symbol_of(input logic [7:0] code);
        case (code)
            8'h16: return 16'h3121;  8'h1E: return 16'h3240;
            8'h26: return 16'h3323;  8'h25: return 16'h3424;
            8'h2E: return 16'h3525;  8'h36: return 16'h365E;
            8'h3D: return 16'h3726;  8'h3E: return 16'h382A;
            8'h46: return 16'h3928;  8'h45: return 16'h3029;
            8'h0E: return 16'h607E;  8'h4E: return 16'h2D5F;
            8'h55: return 16'h3D2B;  8'h54: return 16'h5B7B;
            8'h5B: return 16'h5D7D;  8'h5D: return 16'h5C7C;
            8'h4C: return 16'h3B3A;  8'h52: return 16'h2722;
            8'h41: return 16'h2C3C;  8'h49: return 16'h2E3E;
            8'h4A: return 16'h2F3F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] scan_to_ascii(
        input logic [7:0] code,
        input logic       ext,
        input logic       shift,
        input logic       caps,
        input logic       ctrl
    );
        logic [7:0]  l;
        logic [15:0] s;
        l = letter_of(code);
        s = symbol_of(code);
        if (ext) begin
            case (code)
                8'h5A:   return 8'h0D;
                8'h4A:   return 8'h2F;
                default: return 8'h00;
            endcase
        end else if (l != 8'h00) begin
            if (ctrl)
                return l & 8'h1F;
            else if (shift ^ caps)
                return l - 8'h20;
            else
                return l;
        end else if (s != 16'h0000) begin
            return shift ? s[7:0] : s[15:8];
        end else begin
            case (code)
                8'h29:   return 8'h20;
                8'h5A:   return 8'h0D;
                8'h0D:   return 8'h09;
                8'h66:   return 8'h08;
                8'h76:   return 8'h1B;
                default: return 8'h00;
            endcase
        end
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of key events with registered head.
// Extra pointer MSB distinguishes full from empty.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  key_evt_t din,
    input  logic     pop,
    output key_evt_t dout,
    output logic     empty,
    output logic     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    key_evt_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        do_pop;
    logic        do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot the same cycle, so a full FIFO still accepts
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Event storage, no reset needed behind the empty gate
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointers and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + ONE;
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 key event decoder: prefix FSM, modifiers, ASCII, event queue.
// Byte -> decode register -> FIFO; head valid two cycles after the strobe.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int EMIT_BREAK    = 0,
    parameter int EMIT_UNMAPPED = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_ascii,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       shift,
    output logic       ctrl,
    output logic       caps_lock,
    output logic       overflow
);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] skip_cnt;

    logic key_hit;
    logic key_ext;
    logic key_brk;

    logic lshift_held;
    logic rshift_held;
    logic lctrl_held;
    logic rctrl_held;
    logic caps_held;

    logic       is_lshift;
    logic       is_rshift;
    logic       is_lctrl;
    logic       is_rctrl;
    logic       is_caps;
    logic       is_fake;
    logic       keep;
    logic [7:0] ascii_c;

    logic     dec_valid;
    key_evt_t dec_evt;
    key_evt_t head;
    logic     fifo_empty;

    assign shift = lshift_held | rshift_held;
    assign ctrl  = lctrl_held | rctrl_held;

    // Prefix state register and Pause skip counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else if (scan_valid) begin
            state <= state_nxt;
            if (state == ST_IDLE && scan_code == PFX_E1)
                skip_cnt <= PAUSE_SKIP;
            else if (state == ST_PAUSE)
                skip_cnt <= skip_cnt - 3'd1;
        end
    end

    // Prefix next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (scan_code == PFX_E0)
                    state_nxt = ST_EXT;
                else if (scan_code == PFX_F0)
                    state_nxt = ST_BRK;
                else if (scan_code == PFX_E1)
                    state_nxt = ST_PAUSE;
            end
            ST_EXT: begin
                if (scan_code == PFX_F0)
                    state_nxt = ST_EXT_BRK;
                else
                    state_nxt = ST_IDLE;
            end
            ST_BRK:     state_nxt = ST_IDLE;
            ST_EXT_BRK: state_nxt = ST_IDLE;
            ST_PAUSE: begin
                if (skip_cnt == 3'd1)
                    state_nxt = ST_IDLE;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Key strobe outputs of the prefix FSM
    always_comb begin
        key_hit = 1'b0;
        key_ext = 1'b0;
        key_brk = 1'b0;
        if (scan_valid) begin
            unique case (state)
                ST_IDLE:
                    key_hit = (scan_code != PFX_E0) &&
                              (scan_code != PFX_F0) &&
                              (scan_code != PFX_E1);
                ST_EXT: begin
                    key_hit = (scan_code != PFX_F0);
                    key_ext = 1'b1;
                end
                ST_BRK: begin
                    key_hit = 1'b1;
                    key_brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    key_hit = 1'b1;
                    key_ext = 1'b1;
                    key_brk = 1'b1;
                end
                default: key_hit = 1'b0;
            endcase
        end
    end

    // Classify the key and decide whether it becomes a queued event
    always_comb begin
        is_lshift = !key_ext && scan_code == SC_LSHIFT;
        is_rshift = !key_ext && scan_code == SC_RSHIFT;
        is_lctrl  = !key_ext && scan_code == SC_CTRL;
        is_rctrl  =  key_ext && scan_code == SC_CTRL;
        is_caps   = !key_ext && scan_code == SC_CAPS;
        is_fake   =  key_ext && (scan_code == SC_LSHIFT ||
                                 scan_code == SC_RSHIFT);
        ascii_c   = scan_to_ascii(scan_code, key_ext, shift,
                                  caps_lock, ctrl);
        keep      = key_hit &&
                    !(is_lshift || is_rshift || is_lctrl ||
                      is_rctrl || is_caps || is_fake) &&
                    ((EMIT_BREAK != 0) || !key_brk) &&
                    ((EMIT_UNMAPPED != 0) || ascii_c != 8'h00);
    end

    // Modifier held bits and Caps Lock toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            lctrl_held  <= 1'b0;
            rctrl_held  <= 1'b0;
            caps_held   <= 1'b0;
            caps_lock   <= 1'b0;
        end else if (key_hit) begin
            if (is_lshift)
                lshift_held <= !key_brk;
            if (is_rshift)
                rshift_held <= !key_brk;
            if (is_lctrl)
                lctrl_held <= !key_brk;
            if (is_rctrl)
                rctrl_held <= !key_brk;
            if (is_caps) begin
                if (key_brk) begin
                    caps_held <= 1'b0;
                end else if (!caps_held) begin
                    caps_held <= 1'b1;
                    caps_lock <= !caps_lock;
                end
            end
        end
    end

    // Decode stage register feeding the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid <= 1'b0;
            dec_evt   <= '0;
        end else begin
            dec_valid     <= keep;
            dec_evt.ascii <= ascii_c;
            dec_evt.code  <= scan_code;
            dec_evt.ext   <= key_ext;
            dec_evt.brk   <= key_brk;
        end
    end

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (dec_valid),
        .din      (dec_evt),
        .pop      (evt_ready),
        .dout     (head),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign evt_valid = !fifo_empty;
    assign evt_ascii = head.ascii;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed self-checking bench for ps2_key_event_decoder.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ps2_key_event_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_ascii;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       shift;
    logic       ctrl;
    logic       caps_lock;
    logic       overflow;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    ps2_key_event_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ascii  (evt_ascii),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .shift      (shift),
        .ctrl       (ctrl),
        .caps_lock  (caps_lock),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; consecutive calls give back-to-back bytes
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop(input string tag,
                       input logic [7:0] a,
                       input logic [7:0] c,
                       input logic e,
                       input logic b);
        chk({tag, ".valid"}, {7'd0, evt_valid}, 8'h01);
        chk({tag, ".ascii"}, evt_ascii, a);
        chk({tag, ".code"},  evt_code, c);
        chk({tag, ".ext"},   {7'd0, evt_ext}, {7'd0, e});
        chk({tag, ".brk"},   {7'd0, evt_break}, {7'd0, b});
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".valid"}, {7'd0, evt_valid}, 8'h00);
        chk({tag, ".ascii"}, evt_ascii, 8'h00);
        chk({tag, ".shift"}, {7'd0, shift}, 8'h00);
        chk({tag, ".ctrl"},  {7'd0, ctrl}, 8'h00);
        chk({tag, ".caps"},  {7'd0, caps_lock}, 8'h00);
        chk({tag, ".ovf"},   {7'd0, overflow}, 8'h00);
    endtask

    initial begin
        logic [7:0] digits [9];
        digits = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                   8'h36, 8'h3D, 8'h3E, 8'h46};
        rst        = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        evt_ready  = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk_idle_outs("reset");

        // Plain make, latency of two cycles
        send(8'h1C);
        chk("lat1", {7'd0, evt_valid}, 8'h00);
        idle(1);
        pop("a", 8'h61, 8'h1C, 1'b0, 1'b0);
        send(8'hF0);
        send(8'h1C);
        idle(3);
        chk("brk_dropped", {7'd0, evt_valid}, 8'h00);

        // Shift applies to the following byte only while held
        send(8'h12);
        chk("shift_on", {7'd0, shift}, 8'h01);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        chk("shift_off", {7'd0, shift}, 8'h00);
        send(8'h1C);
        idle(1);
        pop("shA", 8'h41, 8'h1C, 1'b0, 1'b0);
        pop("sha", 8'h61, 8'h1C, 1'b0, 1'b0);

        // Caps Lock with typematic repeat
        send(8'h58);
        chk("caps_on", {7'd0, caps_lock}, 8'h01);
        send(8'h58);
        chk("caps_rep", {7'd0, caps_lock}, 8'h01);
        send(8'hF0);
        send(8'h58);
        send(8'h1C);
        idle(1);
        pop("capsA", 8'h41, 8'h1C, 1'b0, 1'b0);
        send(8'h12);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        pop("capsSh", 8'h61, 8'h1C, 1'b0, 1'b0);
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        chk("caps_off", {7'd0, caps_lock}, 8'h00);

        // Ctrl-C and right-shift symbol
        send(8'h14);
        chk("ctrl_on", {7'd0, ctrl}, 8'h01);
        send(8'h21);
        send(8'hF0);
        send(8'h14);
        chk("ctrl_off", {7'd0, ctrl}, 8'h00);
        idle(1);
        pop("ctlC", 8'h03, 8'h21, 1'b0, 1'b0);
        send(8'h59);
        send(8'h16);
        send(8'hF0);
        send(8'h59);
        pop("bang", 8'h21, 8'h16, 1'b0, 1'b0);

        // Extended keypad Enter and fake shift
        send(8'hE0);
        send(8'h12);
        chk("fake_shift", {7'd0, shift}, 8'h00);
        send(8'hE0);
        send(8'h5A);
        idle(1);
        pop("kpEnt", 8'h0D, 8'h5A, 1'b1, 1'b0);
        chk("fake_noevt", {7'd0, evt_valid}, 8'h00);

        // Pause sequence swallowed entirely
        send(8'hE1);
        send(8'h14);
        chk("pause_ctrl", {7'd0, ctrl}, 8'h00);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        send(8'h77);
        send(8'h16);
        idle(1);
        pop("pause1", 8'h31, 8'h16, 1'b0, 1'b0);
        idle(2);
        chk("pause_one", {7'd0, evt_valid}, 8'h00);

        // Fill past capacity, then drain in order
        for (int i = 0; i < 9; i++)
            send(digits[i]);
        idle(2);
        chk("ovf_set", {7'd0, overflow}, 8'h01);
        for (int i = 0; i < 8; i++)
            pop($sformatf("drain%0d", i), 8'h31 + 8'(i),
                digits[i], 1'b0, 1'b0);
        chk("drained", {7'd0, evt_valid}, 8'h00);
        chk("ovf_sticky", {7'd0, overflow}, 8'h01);

        // Reset mid prefix discards it
        send(8'hE0);
        send(8'hF0);
        rst = 1'b1;
        idle(1);
        chk_idle_outs("midrst");
        rst = 1'b0;
        idle(1);
        send(8'h1C);
        idle(1);
        pop("postrst", 8'h61, 8'h1C, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
- Second-generation PS/2 set-2 decoder. Sits between the PS/2 byte receiver and consumers (terminal, VGA text buffer).
- Consumes raw scan bytes and strips the E0, F0 and E1 prefix sequences.
- Tracks Shift, Ctrl and Caps Lock, and translates make codes to true ASCII (lower/upper case, shifted symbols, control chars).
- Queues key events in a parametrised FIFO with a valid/ready output.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, >=2
EMIT_BREAK, 0, 1 = break (release) events also queued; 0 = only make events queued
EMIT_UNMAPPED, 1, 1 = keys with ascii 0x00 still queued; 0 = dropped

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
scan_valid  in  1  one-cycle strobe, scan_code valid
scan_code  in  8  received PS/2 byte
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head when evt_valid&evt_ready
evt_ascii  out  8  translated ASCII of head event
evt_code  out  8  raw scan code (prefix stripped)
evt_ext  out  1  head event had E0 prefix
evt_break  out  1  head event is a release
shift  out  1  L(12) or R(59) shift held
ctrl  out  1  L(14) or R(E0 14) ctrl held
caps_lock  out  1  caps lock state (LED drive)
overflow  out  1  sticky: an event was dropped because the FIFO was full; cleared only by rst

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Modifiers, held flags, FIFO pointers and the E1 counter are cleared. Reset mid-sequence discards the partial prefix.
- Prefix FSM, advancing only on scan_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip count 7; any other byte -> emit make(code, ext=0).
  - EXT: F0 -> EXT_BRK; any other byte -> emit make(code, ext=1), then IDLE.
  - BRK: any byte -> emit break(code, ext=0), then IDLE.
  - EXT_BRK: any byte -> emit break(code, ext=1), then IDLE.
  - PAUSE: decrement the counter on each byte; return to IDLE after the 7th byte. No events are generated, and modifiers are untouched.
- Modifier keys: make/break of 12, 59, 14 and E0 14 set/clear the individual held bits. shift and ctrl are the OR of the corresponding held bits. These keys are never queued.
  - E0 12 and E0 59 (fake shifts) are ignored entirely.
- Caps Lock (58): the first make toggles caps_lock and sets caps_held. Typematic repeats (make while caps_held) do not toggle. The break clears caps_held. Caps Lock is not queued.
- Translation uses a combinational table held in the package:
  - Letters: 0x61-0x7A, or 0x41-0x5A when shift XOR caps_lock.
  - Digits and symbols: unshifted/shifted pairs ('1'/'!' ... '/'/'?').
  - Fixed codes: space 0x20, Enter 0x0D, Tab 0x09, Backspace(66) 0x08, Esc 0x1B.
  - E0 5A -> 0x0D; E0 4A -> 0x2F. All other extended codes -> 0x00. Function keys -> 0x00.
  - When ctrl=1 and the key is a letter, ascii = letter & 0x1F.
  - Break events carry the same ascii as the make.
- Modifier state applied to an event is the state before that event's byte; this applies equally to back-to-back bytes.
- Latency:
  - The byte accepted at cycle N is registered in a decode stage at the edge ending N.
  - It is written to the FIFO at the edge ending N+1.
  - evt_valid rises in cycle N+2 if the FIFO was empty. Throughput is one event per cycle.
- FIFO:
  - Push while full and no pop in the same cycle: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty is ignored.
  - evt_* outputs hold stable while evt_valid=1 and evt_ready=0. The head is registered (first-word fall-through).
  - Pointers wrap modulo FIFO_DEPTH, with an extra MSB used for the full/empty distinction.
- Modifiers keep updating while the FIFO is full.

Decomposition:
- Package ps2_pkg:
  - prefix byte constants (E0, F0, E1);
  - modifier scan codes;
  - FSM state enum;
  - key event struct {ascii, code, ext, brk};
  - translation function scan_to_ascii(code, ext, shift, caps, ctrl).
- Sub-module ps2_event_fifo: parametrised sync FIFO of event structs with a push/pop/full/empty/overflow interface.

Test Plan:
- Bytes 1C -> one event: ascii 0x61, code 1C, ext 0, brk 0; evt_valid high 2 cycles after the strobe. Then F0 1C -> no event (EMIT_BREAK=0).
- 12, 1C, F0 12, 1C -> two events: 0x41 then 0x61; shift reads 1 then 0.
- 58, 58, F0 58, 1C -> caps_lock=1 (the repeat does not toggle), event 0x41. With 12 held, 1C gives 0x61.
- 14, 21 -> event ascii 0x03. E0 5A -> ascii 0x0D with ext 1. E1 14 77 E1 F0 14 F0 77 then 16 -> exactly one event, 0x31.
- FIFO_DEPTH=8, evt_ready=0, 9 make codes -> 8 held, overflow=1. Then ready=1 -> the first 8 drain in order and overflow stays 1.
- Assert rst after E0 F0 -> outputs 0. Next byte 1C -> make event 0x61 with ext 0, brk 0.
